ring_pe_nic: RTL and testbench

Processing-element network interface for the 4-node bidirectional ring. It sits between a local host/PE and one ring router's PE port. It builds packets from host requests, computes the route direction and hop field, stamps the virtual-channel bit, and drives the router's injection handshake. It also accepts ejected packets from the router, buffers them, and presents payload and source to the host.

---
 rtl/ring_noc_pkg.sv | 46 ++++
 rtl/ring_nic_fifo.sv | 47 ++++
 rtl/ring_pe_nic.sv | 166 ++++++++++++++++
 tb/tb_ring_pe_nic.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_noc_pkg.sv
// Shared definitions for the 4-node bidirectional ring: packet layout and routing.
package ring_noc_pkg;

    localparam int unsigned NUM_NODES = 4;

    // Packet field positions
    localparam int unsigned PKT_W    = 64;
    localparam int unsigned VC_BIT   = 63;
    localparam int unsigned DIR_BIT  = 62;
    localparam int unsigned HOP_MSB  = 55;
    localparam int unsigned HOP_LSB  = 48;
    localparam int unsigned SRC_MSB  = 47;
    localparam int unsigned SRC_LSB  = 32;
    localparam int unsigned PAY_MSB  = 31;

    // TX FIFO keeps everything but the vc bit, which is stamped at injection time
    localparam int unsigned TX_PKT_W = PKT_W - 1;
    // RX FIFO keeps the low two source bits plus payload
    localparam int unsigned RX_PKT_W = 34;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    typedef enum logic {
        StIdle,
        StSend
    } tx_state_e;

    typedef struct packed {
        logic       dir;
        logic [7:0] hop;
        logic       self_addr;
    } route_t;

    // Shortest-path route on a 4-node ring; ties (distance 2) go clockwise.
    function automatic route_t route(input logic [1:0] dest, input logic [1:0] node_id);
        logic [1:0] d;
        route_t     r;
        d           = dest - node_id;
        r.dir       = (d == 2'd3) ? DIR_CCW : DIR_CW;
        r.hop       = (d == 2'd2) ? 8'h03 : 8'h01;
        r.self_addr = (d == 2'd0);
        return r;
    endfunction

endpackage

// File: rtl/ring_nic_fifo.sv
// Synchronous FIFO with occupancy count; full/empty are derived from the count.
module ring_nic_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign do_push = push && (count_q != CW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    // Pointer and count update; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata;
    end

    assign rdata = mem[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/ring_pe_nic.sv
// PE network interface: builds and injects ring packets from host requests and
// buffers ejected packets for the host.
module ring_pe_nic
    import ring_noc_pkg::*;
#(
    parameter int unsigned NODE_ID  = 0,
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        polarity,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [1:0]  tx_dest,
    input  logic [31:0] tx_payload,
    output logic        pesi,
    input  logic        peri,
    output logic [63:0] pedi,
    input  logic        peso,
    output logic        pero,
    input  logic [63:0] pedo,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [1:0]  rx_src,
    output logic [31:0] rx_payload,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count,
    output logic        self_err
);

    localparam int unsigned TXCW = $clog2(TX_DEPTH + 1);
    localparam int unsigned RXCW = $clog2(RX_DEPTH + 1);

    // ---------------- TX path ----------------
    route_t              rt;
    logic                tx_accept, tx_push, tx_pop, tx_done, tx_nonempty;
    logic [TX_PKT_W-1:0] tx_wdata, tx_head;
    logic [TXCW-1:0]     tx_fifo_cnt;
    tx_state_e           state_q, state_d;
    logic [TX_PKT_W-1:0] pedi_q, pedi_d;
    logic [15:0]         tx_count_q;
    logic                self_err_q;

    assign rt        = route(tx_dest, 2'(NODE_ID));
    assign tx_ready  = (tx_fifo_cnt != TXCW'(TX_DEPTH));
    assign tx_accept = tx_valid && tx_ready;
    // Self-addressed requests are consumed but never stored
    assign tx_push   = tx_accept && !rt.self_addr;
    assign tx_wdata  = {rt.dir, 6'b0, rt.hop, 16'(NODE_ID), tx_payload};
    assign tx_nonempty = (tx_fifo_cnt != '0);

    ring_nic_fifo #(
        .WIDTH (TX_PKT_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .wdata (tx_wdata),
        .pop   (tx_pop),
        .rdata (tx_head),
        .count (tx_fifo_cnt)
    );

    // Injection stage next-state: load head when idle or after a completed transfer
    always_comb begin
        state_d = state_q;
        pedi_d  = pedi_q;
        tx_pop  = 1'b0;
        tx_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_nonempty) begin
                    tx_pop  = 1'b1;
                    pedi_d  = tx_head;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (peri) begin
                    tx_done = 1'b1;
                    if (tx_nonempty) begin
                        tx_pop = 1'b1;
                        pedi_d = tx_head;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Injection stage registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pedi_q  <= '0;
        end else begin
            state_q <= state_d;
            pedi_q  <= pedi_d;
        end
    end

    // Saturating injected-packet counter and sticky self-address error
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_count_q <= '0;
            self_err_q <= 1'b0;
        end else begin
            if (tx_done && (tx_count_q != 16'hFFFF)) tx_count_q <= tx_count_q + 16'd1;
            if (tx_accept && rt.self_addr) self_err_q <= 1'b1;
        end
    end

    assign pesi     = (state_q == StSend);
    // vc bit follows ring polarity live while the packet is offered
    assign pedi     = {pesi & polarity, pedi_q};
    assign tx_count = tx_count_q;
    assign self_err = self_err_q;

    // ---------------- RX path ----------------
    logic                rx_push, rx_pop;
    logic [RX_PKT_W-1:0] rx_head;
    logic [RXCW-1:0]     rx_fifo_cnt, rx_cnt_next;
    logic                pero_q;
    logic [15:0]         rx_count_q;
    logic                unused_pedo;

    assign rx_push     = peso && pero_q;
    assign rx_valid    = (rx_fifo_cnt != '0);
    assign rx_pop      = rx_valid && rx_ready;
    assign rx_cnt_next = rx_fifo_cnt + RXCW'(rx_push) - RXCW'(rx_pop);
    assign unused_pedo = ^pedo[63:34];

    ring_nic_fifo #(
        .WIDTH (RX_PKT_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .wdata (pedo[RX_PKT_W-1:0]),
        .pop   (rx_pop),
        .rdata (rx_head),
        .count (rx_fifo_cnt)
    );

    // Ejection ready tracks free space after this cycle's push/pop; saturating counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pero_q     <= 1'b1;
            rx_count_q <= '0;
        end else begin
            pero_q <= (rx_cnt_next != RXCW'(RX_DEPTH));
            if (rx_push && (rx_count_q != 16'hFFFF)) rx_count_q <= rx_count_q + 16'd1;
        end
    end

    assign pero       = pero_q;
    assign rx_count   = rx_count_q;
    assign rx_src     = rx_valid ? rx_head[33:32] : 2'b0;
    assign rx_payload = rx_valid ? rx_head[31:0] : 32'b0;

endmodule

// File: tb/tb_ring_pe_nic.sv
// Bench for ring_pe_nic: two instances (node 0 and node 1) with scoreboards on the
// injection and ejection sides plus a route vector table.
module tb_ring_pe_nic;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic polarity = 1'b0;

    logic        tx_valid [2];
    logic        tx_ready [2];
    logic [1:0]  tx_dest [2];
    logic [31:0] tx_payload [2];
    logic        pesi [2];
    logic        peri [2];
    logic [63:0] pedi [2];
    logic        peso [2];
    logic        pero [2];
    logic [63:0] pedo [2];
    logic        rx_valid [2];
    logic        rx_ready [2];
    logic [1:0]  rx_src [2];
    logic [31:0] rx_payload [2];
    logic [15:0] tx_count [2];
    logic [15:0] rx_count [2];
    logic        self_err [2];

    ring_pe_nic #(.NODE_ID(0), .TX_DEPTH(4), .RX_DEPTH(4)) dut0 (
        .clk(clk), .reset(reset), .polarity(polarity),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx_dest(tx_dest[0]),
        .tx_payload(tx_payload[0]), .pesi(pesi[0]), .peri(peri[0]), .pedi(pedi[0]),
        .peso(peso[0]), .pero(pero[0]), .pedo(pedo[0]), .rx_valid(rx_valid[0]),
        .rx_ready(rx_ready[0]), .rx_src(rx_src[0]), .rx_payload(rx_payload[0]),
        .tx_count(tx_count[0]), .rx_count(rx_count[0]), .self_err(self_err[0])
    );

    ring_pe_nic #(.NODE_ID(1), .TX_DEPTH(4), .RX_DEPTH(4)) dut1 (
        .clk(clk), .reset(reset), .polarity(polarity),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx_dest(tx_dest[1]),
        .tx_payload(tx_payload[1]), .pesi(pesi[1]), .peri(peri[1]), .pedi(pedi[1]),
        .peso(peso[1]), .pero(pero[1]), .pedo(pedo[1]), .rx_valid(rx_valid[1]),
        .rx_ready(rx_ready[1]), .rx_src(rx_src[1]), .rx_payload(rx_payload[1]),
        .tx_count(tx_count[1]), .rx_count(rx_count[1]), .self_err(self_err[1])
    );

    always #5 clk = ~clk;

    // Ring polarity toggles every cycle out of reset
    always @(posedge clk) polarity <= reset ? 1'b0 : ~polarity;

    logic [62:0] txq0[$];
    logic [62:0] txq1[$];
    logic [33:0] rxq[$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent packet model
    function automatic logic [62:0] model_pkt(input int node, input logic [1:0] dest,
                                              input logic [31:0] pay);
        logic [1:0] d;
        d = dest - 2'(node);
        return {(d == 2'd3), 6'b0, (d == 2'd2) ? 8'h03 : 8'h01, 16'(node), pay};
    endfunction

    // One-cycle host write; queues the expected packet if it will be stored
    task automatic tx_drive(input int k, input logic [1:0] dest, input logic [31:0] pay,
                            input logic [62:0] exp, input logic is_self);
        tx_valid[k] = 1'b1;
        tx_dest[k] = dest;
        tx_payload[k] = pay;
        if (tx_ready[k] && !is_self) begin
            if (k == 0) txq0.push_back(exp);
            else txq1.push_back(exp);
        end
        tick();
        tx_valid[k] = 1'b0;
    endtask

    // Offer one ejected packet to node 0; queue it if the NIC is ready
    task automatic rx_drive(input logic [63:0] pkt);
        peso[0] = 1'b1;
        pedo[0] = pkt;
        if (pero[0]) rxq.push_back(pkt[33:0]);
        tick();
        peso[0] = 1'b0;
    endtask

    task automatic mon_tx(input int k);
        logic [62:0] e;
        int sz;
        sz = (k == 0) ? txq0.size() : txq1.size();
        if (pesi[k] && peri[k]) begin
            if (sz == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_spurious%0d: got packet %h, required none", k, pedi[k]);
            end else begin
                if (k == 0) e = txq0.pop_front();
                else e = txq1.pop_front();
                check($sformatf("tx_pkt%0d", k), {1'b0, pedi[k][62:0]}, {1'b0, e});
                check($sformatf("tx_vc%0d", k), {63'b0, pedi[k][63]}, {63'b0, polarity});
            end
        end
    endtask

    // Scoreboard monitors sample mid-cycle, ahead of the edge that transfers
    always @(negedge clk) begin
        if (!reset) begin
            mon_tx(0);
            mon_tx(1);
            if (rx_valid[0] && rx_ready[0]) begin
                if (rxq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_spurious: got %h, required none",
                             {rx_src[0], rx_payload[0]});
                end else begin
                    check("rx_data", {30'b0, rx_src[0], rx_payload[0]},
                          {30'b0, rxq.pop_front()});
                end
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_pesi", {63'b0, pesi[0]}, 64'd0);
        check("rst_pedi", pedi[0], 64'd0);
        check("rst_pero", {63'b0, pero[0]}, 64'd1);
        check("rst_tx_ready", {63'b0, tx_ready[0]}, 64'd1);
        check("rst_rx_valid", {63'b0, rx_valid[0]}, 64'd0);
        check("rst_rx_src", {62'b0, rx_src[0]}, 64'd0);
        check("rst_rx_payload", {32'b0, rx_payload[0]}, 64'd0);
        check("rst_tx_count", {48'b0, tx_count[0]}, 64'd0);
        check("rst_rx_count", {48'b0, rx_count[0]}, 64'd0);
        check("rst_self_err", {63'b0, self_err[0]}, 64'd0);
    endtask

    typedef struct {
        int          inst;
        logic [1:0]  dest;
        logic [31:0] pay;
        logic [62:0] exp;
        logic        is_self;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        int exp_tx [2];
        logic exp_self [2];
        logic [62:0] held;
        int rx_acc;

        vecs[0] = '{0, 2'd1, 32'h1111_0001, {1'b0, 6'b0, 8'h01, 16'h0000, 32'h1111_0001}, 1'b0};
        vecs[1] = '{0, 2'd3, 32'h1111_0003, {1'b1, 6'b0, 8'h01, 16'h0000, 32'h1111_0003}, 1'b0};
        vecs[2] = '{1, 2'd0, 32'h2222_0000, {1'b1, 6'b0, 8'h01, 16'h0001, 32'h2222_0000}, 1'b0};
        vecs[3] = '{1, 2'd2, 32'h2222_0002, {1'b0, 6'b0, 8'h01, 16'h0001, 32'h2222_0002}, 1'b0};
        vecs[4] = '{1, 2'd3, 32'h2222_0003, {1'b0, 6'b0, 8'h03, 16'h0001, 32'h2222_0003}, 1'b0};
        vecs[5] = '{0, 2'd0, 32'h1111_0000, 63'd0, 1'b1};
        vecs[6] = '{1, 2'd1, 32'h2222_0001, 63'd0, 1'b1};

        for (int k = 0; k < 2; k++) begin
            tx_valid[k] = 1'b0;
            tx_dest[k] = 2'd0;
            tx_payload[k] = 32'd0;
            peri[k] = 1'b1;
            peso[k] = 1'b0;
            pedo[k] = 64'd0;
            rx_ready[k] = 1'b0;
            exp_self[k] = 1'b0;
        end

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        check_reset_vals();
        reset = 1'b0;

        // Injection latency: write at edge N, pesi high after edge N+1
        tx_valid[0] = 1'b1;
        tx_dest[0] = 2'd2;
        tx_payload[0] = 32'hDEADBEEF;
        txq0.push_back({1'b0, 6'b0, 8'h03, 16'h0000, 32'hDEADBEEF});
        tick();
        tx_valid[0] = 1'b0;
        check("lat_pesi_n", {63'b0, pesi[0]}, 64'd0);
        tick();
        check("lat_pesi_n1", {63'b0, pesi[0]}, 64'd1);
        check("lat_pedi", {1'b0, pedi[0][62:0]}, {1'b0, 1'b0, 6'b0, 8'h03, 16'h0000, 32'hDEADBEEF});
        check("lat_vc", {63'b0, pedi[0][63]}, {63'b0, polarity});
        tick();
        check("lat_tx_count", {48'b0, tx_count[0]}, 64'd1);
        check("lat_pesi_idle", {63'b0, pesi[0]}, 64'd0);
        exp_tx[0] = 1;
        exp_tx[1] = 0;

        // Route table on both nodes
        for (int i = 0; i < 7; i++) begin
            tx_drive(vecs[i].inst, vecs[i].dest, vecs[i].pay, vecs[i].exp, vecs[i].is_self);
            repeat (4) tick();
            if (vecs[i].is_self) exp_self[vecs[i].inst] = 1'b1;
            else exp_tx[vecs[i].inst]++;
            check($sformatf("route%0d_count", i), {48'b0, tx_count[vecs[i].inst]},
                  64'(exp_tx[vecs[i].inst]));
            check($sformatf("route%0d_self_err", i), {63'b0, self_err[vecs[i].inst]},
                  {63'b0, exp_self[vecs[i].inst]});
        end
        check("route_q0_drained", 64'(txq0.size()), 64'd0);
        check("route_q1_drained", 64'(txq1.size()), 64'd0);

        // Backpressure: register plus 4 FIFO entries absorb 5 writes, the 6th is refused
        peri[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_ready%0d", i), {63'b0, tx_ready[0]}, {63'b0, (i < 5)});
            tx_drive(0, 2'd1, 32'hA000_0000 + 32'(i), model_pkt(0, 2'd1, 32'hA000_0000 + 32'(i)),
                     1'b0);
        end
        held = pedi[0][62:0];
        check("bp_head", {1'b0, held}, {1'b0, model_pkt(0, 2'd1, 32'hA000_0000)});
        for (int i = 0; i < 2; i++) begin
            tick();
            check("bp_hold", {1'b0, pedi[0][62:0]}, {1'b0, held});
            check("bp_vc", {63'b0, pedi[0][63]}, {63'b0, polarity});
            check("bp_pesi", {63'b0, pesi[0]}, 64'd1);
        end
        peri[0] = 1'b1;
        repeat (8) tick();
        check("bp_drained", 64'(txq0.size()), 64'd0);
        check("bp_tx_count", {48'b0, tx_count[0]}, 64'(exp_tx[0] + 5));

        // RX burst of 6 with host stalled: only 4 accepted
        rx_acc = 0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rx_pero%0d", i), {63'b0, pero[0]}, {63'b0, (i < 4)});
            if (pero[0]) rx_acc++;
            rx_drive({30'h2ABC_DEF0, 2'(i), 32'hC000_0000 + 32'(i)});
            if (i == 0) check("rx_latency", {63'b0, rx_valid[0]}, 64'd1);
        end
        check("rx_accepted", 64'(rx_acc), 64'd4);
        check("rx_count4", {48'b0, rx_count[0]}, 64'd4);
        check("rx_pero_full", {63'b0, pero[0]}, 64'd0);
        rx_ready[0] = 1'b1;
        repeat (6) tick();
        check("rx_drained", 64'(rxq.size()), 64'd0);
        check("rx_valid_empty", {63'b0, rx_valid[0]}, 64'd0);
        rx_ready[0] = 1'b0;

        // One free entry: simultaneous push+pop keeps pero high, push alone drops it
        for (int i = 0; i < 3; i++) rx_drive({30'h0, 2'd3, 32'hD000_0000 + 32'(i)});
        rx_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rx_pp_pero%0d", i), {63'b0, pero[0]}, 64'd1);
            rx_drive({30'h0, 2'(i), 32'hE000_0000 + 32'(i)});
        end
        rx_ready[0] = 1'b0;
        check("rx_last_free", {63'b0, pero[0]}, 64'd1);
        rx_drive({30'h0, 2'd2, 32'hF000_0000});
        check("rx_pero_drop", {63'b0, pero[0]}, 64'd0);
        check("rx_count11", {48'b0, rx_count[0]}, 64'd11);
        rx_ready[0] = 1'b1;
        repeat (6) tick();
        check("rx_pp_drained", 64'(rxq.size()), 64'd0);
        rx_ready[0] = 1'b0;

        // Reset mid-transfer with packets buffered on both sides
        peri[0] = 1'b0;
        for (int i = 0; i < 4; i++)
            tx_drive(0, 2'd3, 32'hB000_0000 + 32'(i), model_pkt(0, 2'd3, 32'hB000_0000 + 32'(i)),
                     1'b0);
        for (int i = 0; i < 3; i++) rx_drive({30'h0, 2'd1, 32'h9000_0000 + 32'(i)});
        check("mid_pesi", {63'b0, pesi[0]}, 64'd1);
        reset = 1'b1;
        tick();
        txq0.delete();
        txq1.delete();
        rxq.delete();
        check_reset_vals();
        check("rst_self_err1", {63'b0, self_err[1]}, 64'd0);
        reset = 1'b0;
        peri[0] = 1'b1;
        repeat (4) tick();
        check("post_rst_pesi", {63'b0, pesi[0]}, 64'd0);
        check("post_rst_tx_count", {48'b0, tx_count[0]}, 64'd0);
        check("post_rst_rx_valid", {63'b0, rx_valid[0]}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
